gray_count_decoder: RTL and testbench
=====================================

// Module: gray_count_decoder
// PURPOSE
//  Receiving end of the binary-to-Gray count link: samples a Gray-coded count word,
//  decodes it back to binary and checks that each new sample is exactly one count step
//  after the previous one. Sits after the counter + binary-to-Gray encoder path, or at
//  the far side of the FPGA pins. Flags step errors, keeps a saturating error tally and
//  reports lock status.
// PARAMETERS
//  WIDTH      3  count/Gray word width in bits (>=2)
//  ERR_CNT_W  8  width of the saturating error counter
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  clr_n      in   1          synchronous active-low reset
//  in_valid   in   1          gray_in carries a new sample this cycle
//  gray_in    in   WIDTH      Gray-coded count word
//  bin_out    out  WIDTH      decoded binary value of last accepted sample
//  out_valid  out  1          one-cycle pulse: bin_out updated this cycle
//  step_err   out  1          one-cycle pulse, coincident with out_valid: step check failed
//  locked     out  1          a reference sample is held and the last check passed
//  err_count  out  ERR_CNT_W  number of step errors since reset, saturating
// BEHAVIOUR
//  - Reset (clr_n==0 at rising clk): bin_out=0, out_valid=0, step_err=0, locked=0,
//    err_count=0, state=IDLE, prev=0. Reset wins over in_valid in the same cycle; a reset
//    mid-stream discards the reference sample.
//  - Decode: bin[WIDTH-1]=g[WIDTH-1]; bin[i]=bin[i+1]^g[i]. Purely combinational.
//  - Latency: 1 cycle. A sample accepted at edge N appears on bin_out with out_valid=1
//    (and step_err if applicable) after edge N. With in_valid=0, out_valid=0,
//    step_err=0 and bin_out holds its value.
//  - FSM, two states:
//    IDLE : on in_valid, store decoded value as prev, pulse out_valid, no check,
//           step_err=0, locked stays 0, go to TRACK.
//    TRACK: on in_valid, expected = prev+1 mod 2^WIDTH (wrap-around: 2^WIDTH-1 -> 0 passes).
//           Match: locked=1, step_err=0.
//           Mismatch (including repeated value or skip): step_err=1, locked=0,
//           err_count+1 unless it already equals 2^ERR_CNT_W-1 (stays there).
//           In both cases the new value becomes prev (re-sync on next sample); stay TRACK.
//  - Gray-domain sanity: a sample whose Gray word differs from the previous Gray word in
//    more than one bit always fails the check, even if its binary is the expected value.
//  - Unsigned arithmetic only; increment truncates to WIDTH bits.
// CONFIGURATION
//  GRAY_DIR_DETECT_EN
//   defined  : TRACK also accepts expected-down (prev-1 mod 2^WIDTH) as a pass. Adds
//              output port `dir` (1 bit, reset 0): 1 = last passing step was up, 0 = down.
//              dir holds on errors.
//   undefined: only up-steps pass; a down-step is a step error; there is no `dir` port.
// STRUCTURE
//  - Shared package gray_pkg: FSM state encoding (ST_IDLE=1'b0, ST_TRACK=1'b1) and the
//    default WIDTH; it is used by the encoder side too.
//  - One sub-module: gray_to_bin (parameter WIDTH; in gray, out bin), a combinational
//    decoder that is reusable elsewhere. Top level holds the FSM, prev register, check
//    logic and error counter.
// TESTING (WIDTH=3, ERR_CNT_W=8)
//  1. Reset, then Gray 000,001,011,010,110,111,101,100,000, one sample per cycle
//     -> bin_out 0..7,0 one cycle later; first out_valid with locked=0; locked=1 from the
//     second; step_err never set; err_count=0 (wrap 7->0 passes).
//  2. Sample gaps: same sequence with in_valid low 2 cycles between samples -> out_valid
//     only after sampled edges, bin_out holds, no errors.
//  3. Skip: 000,001,010(Gray=3) -> step_err pulse on third output, locked=0, err_count=1;
//     next 110 (bin 4) passes -> locked=1.
//  4. Repeat 011,011 -> second is an error; 300 consecutive bad samples -> err_count
//     saturates at 255.
//  5. clr_n low for one cycle mid-stream while in_valid=1 -> all outputs zero, state IDLE;
//     next sample accepted with no check, locked=0.
//  6. With GRAY_DIR_DETECT_EN: 010,011,001 (bin 3,2,1) -> no errors, dir=0, locked=1;
//     without the macro -> two step errors, err_count=2.

Source files
------------

// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : gray_pkg
//  Description: Shared definitions for the binary/Gray count link: the
//               decoder FSM state encoding and the default count width.
//  Revision   : 1.0 - initial release
// ============================================================================
package gray_pkg;

    // Decoder FSM states: waiting for a reference sample, or tracking steps
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // Default count/Gray word width shared by encoder and decoder sides
    localparam int GRAY_WIDTH_DEFAULT = 3;

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_to_bin.sv
`default_nettype none
// ============================================================================
//  Module     : gray_to_bin
//  Description: Combinational Gray-to-binary decoder. Each binary bit is the
//               XOR of all Gray bits at or above its position.
//  Revision   : 1.0 - initial release
// ============================================================================
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Ripple the XOR prefix down from the MSB
    always_comb begin
        bin            = '0;
        bin[WIDTH-1]   = gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule : gray_to_bin
`default_nettype wire

// File: rtl/gray_count_decoder.sv
`default_nettype none
// ============================================================================
//  Module     : gray_count_decoder
//  Description: Samples a Gray-coded count, decodes it to binary and checks
//               that each sample is exactly one count step after the last.
//               Reports step errors, a saturating error tally and lock.
//               Optional macro GRAY_DIR_DETECT_EN: down-steps also pass and
//               a `dir` output reports the direction of the last good step.
//  Revision   : 1.0 - initial release
// ============================================================================
module gray_count_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH     = GRAY_WIDTH_DEFAULT,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     gray_in,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 out_valid,
    output logic                 step_err,
    output logic                 locked,
    output logic [ERR_CNT_W-1:0] err_count
`ifdef GRAY_DIR_DETECT_EN
    ,
    output logic                 dir
`endif
);

    localparam logic [WIDTH-1:0]     ONE_W   = WIDTH'(1);
    localparam logic [ERR_CNT_W-1:0] ONE_E   = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       prev_q, prev_d;         // binary reference sample
    logic [WIDTH-1:0]       prev_gray_q, prev_gray_d; // Gray word of the reference
    logic [WIDTH-1:0]       bin_q, bin_d;
    logic                   out_valid_q, out_valid_d;
    logic                   step_err_q, step_err_d;
    logic                   locked_q, locked_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
`ifdef GRAY_DIR_DETECT_EN
    logic                   dir_q, dir_d;
`endif

    logic [WIDTH-1:0]       dec_bin;
    logic [WIDTH-1:0]       exp_up;
    logic [WIDTH-1:0]       gray_diff;
    logic                   multi_bit;
    logic                   up_ok;
    logic                   down_ok;
    logic                   step_ok;

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_gray_to_bin (
        .gray (gray_in),
        .bin  (dec_bin)
    );

    // Step check: binary must be prev+1 (or prev-1 when direction detect is
    // built in) and the Gray word may change in at most one bit.
    always_comb begin
        exp_up    = prev_q + ONE_W;
        gray_diff = prev_gray_q ^ gray_in;
        multi_bit = (gray_diff & (gray_diff - ONE_W)) != '0;
        up_ok     = !multi_bit && (dec_bin == exp_up);
`ifdef GRAY_DIR_DETECT_EN
        down_ok   = !multi_bit && (dec_bin == (prev_q - ONE_W));
`else
        down_ok   = 1'b0;
`endif
        step_ok   = up_ok || down_ok;
    end

    // Next-state and output logic for the IDLE/TRACK FSM
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        prev_gray_d = prev_gray_q;
        bin_d       = bin_q;
        out_valid_d = 1'b0;
        step_err_d  = 1'b0;
        locked_d    = locked_q;
        err_cnt_d   = err_cnt_q;
`ifdef GRAY_DIR_DETECT_EN
        dir_d       = dir_q;
`endif
        if (in_valid) begin
            // Every accepted sample becomes the new reference (re-sync)
            prev_d      = dec_bin;
            prev_gray_d = gray_in;
            bin_d       = dec_bin;
            out_valid_d = 1'b1;
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (step_ok) begin
                        locked_d = 1'b1;
`ifdef GRAY_DIR_DETECT_EN
                        dir_d    = up_ok;
`endif
                    end else begin
                        step_err_d = 1'b1;
                        locked_d   = 1'b0;
                        if (err_cnt_q != ERR_MAX) begin
                            err_cnt_d = err_cnt_q + ONE_E;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers; reset discards the reference sample and wins over in_valid
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q     <= ST_IDLE;
            prev_q      <= '0;
            prev_gray_q <= '0;
            bin_q       <= '0;
            out_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
            locked_q    <= 1'b0;
            err_cnt_q   <= '0;
`ifdef GRAY_DIR_DETECT_EN
            dir_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            prev_gray_q <= prev_gray_d;
            bin_q       <= bin_d;
            out_valid_q <= out_valid_d;
            step_err_q  <= step_err_d;
            locked_q    <= locked_d;
            err_cnt_q   <= err_cnt_d;
`ifdef GRAY_DIR_DETECT_EN
            dir_q       <= dir_d;
`endif
        end
    end

    assign bin_out   = bin_q;
    assign out_valid = out_valid_q;
    assign step_err  = step_err_q;
    assign locked    = locked_q;
    assign err_count = err_cnt_q;
`ifdef GRAY_DIR_DETECT_EN
    assign dir       = dir_q;
`endif

endmodule : gray_count_decoder
`default_nettype wire

// File: tb/tb_gray_count_decoder.sv
`default_nettype none
// ============================================================================
//  Module     : tb_gray_count_decoder
//  Description: Directed self-checking bench for gray_count_decoder
//               (WIDTH=3, ERR_CNT_W=8). Honours GRAY_DIR_DETECT_EN.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_gray_count_decoder;

    localparam int WIDTH     = 3;
    localparam int ERR_CNT_W = 8;

    logic                 clk;
    logic                 clr_n;
    logic                 in_valid;
    logic [WIDTH-1:0]     gray_in;
    logic [WIDTH-1:0]     bin_out;
    logic                 out_valid;
    logic                 step_err;
    logic                 locked;
    logic [ERR_CNT_W-1:0] err_count;
`ifdef GRAY_DIR_DETECT_EN
    logic                 dir;
`endif

    int n_checks = 0;
    int n_errors = 0;

    gray_count_decoder #(
        .WIDTH     (WIDTH),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_valid  (in_valid),
        .gray_in   (gray_in),
        .bin_out   (bin_out),
        .out_valid (out_valid),
        .step_err  (step_err),
        .locked    (locked),
        .err_count (err_count)
`ifdef GRAY_DIR_DETECT_EN
        ,
        .dir       (dir)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of input at the falling edge, then sample 1 after the rising edge
    task automatic drive(input logic v, input logic [WIDTH-1:0] g);
        @(negedge clk);
        in_valid = v;
        gray_in  = g;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v, input logic [WIDTH-1:0] g);
        @(negedge clk);
        clr_n    = 1'b0;
        in_valid = v;
        gray_in  = g;
        @(posedge clk);
        #1;
        clr_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int b, input int ov,
                           input int se, input int lk, input int ec);
        chk({tag, ".bin_out"},   int'(bin_out),   b);
        chk({tag, ".out_valid"}, int'(out_valid), ov);
        chk({tag, ".step_err"},  int'(step_err),  se);
        chk({tag, ".locked"},    int'(locked),    lk);
        chk({tag, ".err_count"}, int'(err_count), ec);
    endtask

    logic [WIDTH-1:0] seq [9];

    initial begin
        seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        clr_n    = 1'b0;
        in_valid = 1'b0;
        gray_in  = '0;

        // Reset state
        do_reset(1'b0, 3'b000);
        do_reset(1'b0, 3'b000);
        chk_all("reset", 0, 0, 0, 0, 0);
`ifdef GRAY_DIR_DETECT_EN
        chk("reset.dir", int'(dir), 0);
`endif

        // 1: full count including the 7->0 wrap, back-to-back samples
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, seq[i]);
            chk_all($sformatf("t1[%0d]", i), i % 8, 1, 0, (i > 0) ? 1 : 0, 0);
        end
        drive(1'b0, 3'b111);
        chk_all("t1.idle", 0, 0, 0, 1, 0);

        // 2: two idle cycles between samples; bin_out must hold
        do_reset(1'b0, 3'b000);
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, seq[i]);
            chk_all($sformatf("t2[%0d]", i), i % 8, 1, 0, (i > 0) ? 1 : 0, 0);
            drive(1'b0, 3'b101);
            chk_all($sformatf("t2g[%0d]", i), i % 8, 0, 0, (i > 0) ? 1 : 0, 0);
            drive(1'b0, 3'b010);
            chk_all($sformatf("t2h[%0d]", i), i % 8, 0, 0, (i > 0) ? 1 : 0, 0);
        end

        // 3: skip 1 -> 3 is an error, then 3 -> 4 re-locks
        do_reset(1'b0, 3'b000);
        drive(1'b1, 3'b000);
        chk_all("t3.s0", 0, 1, 0, 0, 0);
        drive(1'b1, 3'b001);
        chk_all("t3.s1", 1, 1, 0, 1, 0);
        drive(1'b1, 3'b010);
        chk_all("t3.skip", 3, 1, 1, 0, 1);
        drive(1'b1, 3'b110);
        chk_all("t3.relock", 4, 1, 0, 1, 1);

        // 4: 4 -> 2 is an error, repeated 2 is an error, then saturate at 255
        drive(1'b1, 3'b011);
        chk_all("t4.back", 2, 1, 1, 0, 2);
        drive(1'b1, 3'b011);
        chk_all("t4.repeat", 2, 1, 1, 0, 3);
        for (int k = 1; k <= 300; k++) begin
            drive(1'b1, 3'b011);
            chk($sformatf("t4.sat[%0d].err_count", k), int'(err_count),
                (3 + k > 255) ? 255 : 3 + k);
        end
        chk_all("t4.sat_end", 2, 1, 1, 0, 255);

        // 5: reset with in_valid high mid-stream discards the reference
        do_reset(1'b0, 3'b000);
        drive(1'b1, 3'b000);
        drive(1'b1, 3'b001);
        drive(1'b1, 3'b011);
        chk_all("t5.pre", 2, 1, 0, 1, 0);
        do_reset(1'b1, 3'b010);
        chk_all("t5.clr", 0, 0, 0, 0, 0);
        drive(1'b1, 3'b111);
        chk_all("t5.first", 5, 1, 0, 0, 0);
        drive(1'b1, 3'b101);
        chk_all("t5.second", 6, 1, 0, 1, 0);

        // 6: down-count 3,2,1
        do_reset(1'b0, 3'b000);
        drive(1'b1, 3'b010);
        chk_all("t6.s0", 3, 1, 0, 0, 0);
        drive(1'b1, 3'b011);
`ifdef GRAY_DIR_DETECT_EN
        chk_all("t6.s1", 2, 1, 0, 1, 0);
        chk("t6.s1.dir", int'(dir), 0);
`else
        chk_all("t6.s1", 2, 1, 1, 0, 1);
`endif
        drive(1'b1, 3'b001);
`ifdef GRAY_DIR_DETECT_EN
        chk_all("t6.s2", 1, 1, 0, 1, 0);
        chk("t6.s2.dir", int'(dir), 0);
        drive(1'b1, 3'b011);
        chk_all("t6.up", 2, 1, 0, 1, 0);
        chk("t6.up.dir", int'(dir), 1);
`else
        chk_all("t6.s2", 1, 1, 1, 0, 2);
`endif

        drive(1'b0, 3'b000);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_gray_count_decoder
`default_nettype wire
